// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the SRAM/UART bus controller:
//   - state_t        : controller state encoding
//   - UART_*_ADDR    : default CPU addresses of the UART data/status registers
//   - STB_ON/STB_OFF : levels of the active-low board strobes
//   - timer_width()  : width of a down-counter able to hold max(a, b)
// -----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      URD,
      UWAIT,
      UWR,
      UHOLD,
      DONE
   } state_t;

   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

   localparam logic STB_ON  = 1'b0;
   localparam logic STB_OFF = 1'b1;

   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/strobe_timer.sv
// -----------------------------------------------------------------------------
// strobe_timer
// Load/count down-counter shared by every timed controller state.
// Ports:
//   CLK      in  clock
//   RST      in  synchronous active-high reset (count cleared to 0)
//   load     in  reload the counter with load_val this edge
//   load_val in  cycles-minus-one of the coming timed state
//   done     out count has reached 0 (last cycle of the timed state)
// -----------------------------------------------------------------------------
module strobe_timer
   import bus_pkg::*;
#(
   parameter int unsigned W = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mem_uart_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_uart_bus_ctrl
// Bridges the CPU MEM-stage port onto an async SRAM and a UART that share one
// data bus. Each request is a req/ack transaction; the pipeline stalls on busy.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   req, rd, wr           request and access type (sampled only in IDLE)
//   addr, wdata           CPU address and write data
//   rdata, ack, busy, err read data, completion pulse, stall, illegal pulse
//   ram_en_n/oe_n/we_n    SRAM strobes (active low)
//   ram_addr              SRAM word address (CPU address zero-extended)
//   ram_data              shared SRAM/UART data bus (tri-state)
//   tbre, tsre, data_ready UART status inputs
//   rdn, wrn              UART read/write strobes (active low)
// -----------------------------------------------------------------------------
module mem_uart_bus_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned        CPU_AW     = 16,
   parameter int unsigned        RAM_AW     = 18,
   parameter int unsigned        DW         = 16,
   parameter logic [CPU_AW-1:0]  UART_DATA  = CPU_AW'(UART_DATA_ADDR),
   parameter logic [CPU_AW-1:0]  UART_STAT  = CPU_AW'(UART_STAT_ADDR),
   parameter int unsigned        WAIT_CYC   = 1,
   parameter int unsigned        UART_PULSE = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req,
   input  logic              rd,
   input  logic              wr,
   input  logic [CPU_AW-1:0] addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata,
   output logic              ack,
   output logic              busy,
   output logic              err,
   output logic              ram_en_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [RAM_AW-1:0] ram_addr,
   inout  wire  [DW-1:0]     ram_data,
   input  logic              tbre,
   input  logic              tsre,
   input  logic              data_ready,
   output logic              rdn,
   output logic              wrn
);

   localparam int unsigned TW       = timer_width(WAIT_CYC, UART_PULSE);
   localparam logic [TW-1:0] WAIT_LD  = TW'(WAIT_CYC - 1);
   localparam logic [TW-1:0] PULSE_LD = TW'(UART_PULSE - 1);

   state_t        state;
   logic          rd_q;
   logic          wr_q;
   logic          drive_q;
   logic [DW-1:0] wdata_q;
   logic          accept;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_done;

   assign accept = (state == IDLE) && req && (rd || wr);
   assign busy   = (state != IDLE);

   // The timer is reloaded in every untimed state, so it always enters a timed
   // state holding that state's length minus one. Only SETUP leads to ACCESS;
   // every other path into a timed state is a UART strobe.
   assign tmr_load = !((state == ACCESS) || (state == URD) || (state == UWR));
   assign tmr_val  = (state == SETUP) ? WAIT_LD : PULSE_LD;

   strobe_timer #(
      .W (TW)
   ) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Write data only matters while the bus is driven; no reset needed.
   always_ff @(posedge CLK) begin
      if (accept) begin
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         drive_q  <= 1'b0;
         ram_en_n <= STB_OFF;
         ram_oe_n <= STB_OFF;
         ram_we_n <= STB_OFF;
         rdn      <= STB_OFF;
         wrn      <= STB_OFF;
         ack      <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         ram_addr <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  rd_q <= rd;
                  wr_q <= wr;
                  if (rd && wr) begin
                     state <= DONE;
                     ack   <= 1'b1;
                     err   <= 1'b1;
                  end else if (addr == UART_STAT) begin
                     // Status is a snapshot of the accept cycle; writes are dropped.
                     if (rd) begin
                        rdata <= DW'({data_ready, tbre & tsre});
                     end
                     state <= DONE;
                     ack   <= 1'b1;
                  end else if (addr == UART_DATA) begin
                     if (rd) begin
                        state <= URD;
                        rdn   <= STB_ON;
                     end else begin
                        state <= UWAIT;
                     end
                  end else begin
                     state    <= SETUP;
                     ram_addr <= RAM_AW'(addr);
                     ram_en_n <= STB_ON;
                     drive_q  <= wr;
                  end
               end
            end
            SETUP: begin
               state    <= ACCESS;
               ram_oe_n <= rd_q ? STB_ON : STB_OFF;
               ram_we_n <= wr_q ? STB_ON : STB_OFF;
            end
            ACCESS: begin
               if (tmr_done) begin
                  if (rd_q) begin
                     rdata <= ram_data;
                  end
                  state    <= DONE;
                  ack      <= 1'b1;
                  ram_en_n <= STB_OFF;
                  ram_oe_n <= STB_OFF;
                  ram_we_n <= STB_OFF;
                  drive_q  <= 1'b0;
               end
            end
            URD: begin
               if (tmr_done) begin
                  rdata <= DW'(ram_data[7:0]);
                  rdn   <= STB_OFF;
                  state <= DONE;
                  ack   <= 1'b1;
               end
            end
            UWAIT: begin
               // Back-pressure: wait for both TX buffer and shifter to drain.
               if (tbre && tsre) begin
                  state   <= UWR;
                  wrn     <= STB_ON;
                  drive_q <= 1'b1;
               end
            end
            UWR: begin
               if (tmr_done) begin
                  state <= UHOLD;
                  wrn   <= STB_OFF;
               end
            end
            UHOLD: begin
               // Data held one cycle past the wrn rising edge for UART hold time.
               state   <= DONE;
               drive_q <= 1'b0;
               ack     <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign ram_data = drive_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_uart_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_uart_bus_ctrl
// Self-checking bench: directed vector table, randomized transactions against a
// transaction-level model, and hand-written reset / held-request sequences.
// -----------------------------------------------------------------------------
module tb_mem_uart_bus_ctrl;

   localparam int W = 3;
   localparam int P = 2;
   localparam logic [15:0] UDATA = 16'hBF00;
   localparam logic [15:0] USTAT = 16'hBF01;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        ack, busy, err;
   logic        ram_en_n, ram_oe_n, ram_we_n;
   logic [17:0] ram_addr;
   wire  [15:0] ram_data;
   logic        tbre = 1'b1;
   logic        tsre = 1'b1;
   logic        data_ready = 1'b0;
   logic        rdn, wrn;

   // Environment: async SRAM and UART RX register driving the shared bus.
   logic [15:0] sram [0:1023] = '{default: 16'h0000};
   logic        force_drv = 1'b0;
   logic [15:0] pat = '0;
   logic [15:0] rx_val = '0;

   assign ram_data = (force_drv || (!ram_en_n && !ram_oe_n) || !rdn) ?
                     (force_drv ? pat : (!rdn ? rx_val : sram[ram_addr[9:0]])) : 16'bz;

   always @(posedge CLK) begin
      if (!ram_en_n && !ram_we_n) sram[ram_addr[9:0]] <= ram_data;
   end

   always #5 CLK = ~CLK;

   mem_uart_bus_ctrl #(
      .WAIT_CYC   (W),
      .UART_PULSE (P)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req        (req),
      .rd         (rd),
      .wr         (wr),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ack        (ack),
      .busy       (busy),
      .err        (err),
      .ram_en_n   (ram_en_n),
      .ram_oe_n   (ram_oe_n),
      .ram_we_n   (ram_we_n),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .tbre       (tbre),
      .tsre       (tsre),
      .data_ready (data_ready),
      .rdn        (rdn),
      .wrn        (wrn)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Observations of one transaction
   int          m_lat, m_en, m_oe, m_we, m_rdn, m_wrn, m_ovl;
   int          m_addr_bad, m_bus_bad, m_busy_bad, m_ack_stb, m_ack_after, m_busy_after, m_rel_bad;
   logic [15:0] m_rdata;
   logic        m_err;

   task automatic do_access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                            input logic dr, input logic tb, input logic ts0, input int k,
                            input logic [15:0] rx);
      logic prev_wrn_low;
      m_lat = -1; m_en = 0; m_oe = 0; m_we = 0; m_rdn = 0; m_wrn = 0; m_ovl = 0;
      m_addr_bad = 0; m_bus_bad = 0; m_busy_bad = 0; m_ack_stb = 0;
      m_rdata = '0; m_err = 1'b0;
      rd = r; wr = w; addr = a; wdata = d; data_ready = dr; tbre = tb; tsre = ts0; rx_val = rx;
      req = 1'b1;
      @(posedge CLK); #1;
      req = 1'b0; rd = 1'b0; wr = 1'b0;
      prev_wrn_low = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (ack) begin
            m_lat = cyc; m_rdata = rdata; m_err = err;
            m_ack_stb = {ram_en_n, ram_oe_n, ram_we_n, rdn, wrn};
            break;
         end
         if (!busy) m_busy_bad++;
         if (!ram_en_n) begin
            m_en++;
            if (ram_addr !== {2'b00, a}) m_addr_bad++;
            if (w && !r && ram_data !== d) m_bus_bad++;
         end
         if (!ram_oe_n) m_oe++;
         if (!ram_we_n) m_we++;
         if (!rdn) m_rdn++;
         if (!wrn) begin
            m_wrn++;
            if (ram_data !== d) m_bus_bad++;
         end else if (prev_wrn_low && ram_data !== d) begin
            m_bus_bad++;
         end
         if ((!ram_oe_n && !ram_we_n) || (!rdn && !wrn)) m_ovl++;
         prev_wrn_low = !wrn;
         tsre = (cyc > k);
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      m_ack_after = ack; m_busy_after = busy;
      pat = 16'hC3A5 ^ d; force_drv = 1'b1;
      #1;
      m_rel_bad = (ram_data !== pat);
      force_drv = 1'b0; tsre = 1'b1; tbre = 1'b1;
   endtask

   // Transaction-level reference model
   logic [15:0] mem_ref [0:1023] = '{default: 16'h0000};
   logic [15:0] prev_rdata = '0;

   task automatic run_op(input string tag, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic dr, input logic tb, input logic ts0,
                         input int k, input logic [15:0] rx);
      logic ill, stat, ur, uw, sram_op;
      int exp_lat;
      logic [15:0] exp_rd;
      ill     = r && w;
      stat    = !ill && (a == USTAT);
      ur      = !ill && (a == UDATA) && r;
      uw      = !ill && (a == UDATA) && w;
      sram_op = !ill && !stat && (a != UDATA);
      exp_rd  = prev_rdata;
      if (ill || stat) exp_lat = 1;
      else if (ur)     exp_lat = P + 1;
      else if (uw)     exp_lat = k + P + 3;
      else             exp_lat = W + 2;
      if (stat && r)    exp_rd = {14'h0, dr, tb & ts0};
      if (ur)           exp_rd = {8'h00, rx[7:0]};
      if (sram_op && r) exp_rd = mem_ref[a[9:0]];

      do_access(r, w, a, d, dr, tb, ts0, k, rx);

      chk({tag, " latency"}, m_lat, exp_lat);
      if (r || ill) chk({tag, " rdata"}, m_rdata, exp_rd);
      chk({tag, " err"}, m_err, ill);
      chk({tag, " en_cycles"}, m_en, sram_op ? W + 1 : 0);
      chk({tag, " oe_cycles"}, m_oe, (sram_op && r) ? W : 0);
      chk({tag, " we_cycles"}, m_we, (sram_op && w) ? W : 0);
      chk({tag, " rdn_cycles"}, m_rdn, ur ? P : 0);
      chk({tag, " wrn_cycles"}, m_wrn, uw ? P : 0);
      chk({tag, " overlap"}, m_ovl, 0);
      chk({tag, " ram_addr"}, m_addr_bad, 0);
      chk({tag, " bus_data"}, m_bus_bad, 0);
      chk({tag, " busy_during"}, m_busy_bad, 0);
      chk({tag, " strobes_at_ack"}, m_ack_stb, 5'h1F);
      chk({tag, " ack_after"}, m_ack_after, 0);
      chk({tag, " busy_after"}, m_busy_after, 0);
      chk({tag, " bus_released"}, m_rel_bad, 0);

      if (sram_op && w) mem_ref[a[9:0]] = d;
      if (r && !ill && !(stat && !r)) begin
         if (!(a == USTAT && !r)) prev_rdata = exp_rd;
      end
   endtask

   typedef struct {
      string       name;
      logic        r, w;
      logic [15:0] a, d;
      logic        dr, tb, ts0;
      int          k;
      logic [15:0] rx;
   } vec_t;

   vec_t vecs [10];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acks, consec, seen;
      logic prev_ack;

      vecs[0] = '{"sram_wr_42",   1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 1'b1, 1'b1, 0, 16'h0000};
      vecs[1] = '{"sram_rd_42",   1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b1, 1'b1, 0, 16'h0000};
      vecs[2] = '{"stat_rd",      1'b1, 1'b0, USTAT,    16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'h0000};
      vecs[3] = '{"uart_wr_wait", 1'b0, 1'b1, UDATA,    16'h0041, 1'b0, 1'b1, 1'b0, 5, 16'h0000};
      vecs[4] = '{"uart_rd",      1'b1, 1'b0, UDATA,    16'h0000, 1'b1, 1'b1, 1'b1, 0, 16'hAB55};
      vecs[5] = '{"illegal",      1'b1, 1'b1, 16'h0010, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0, 16'h0000};
      vecs[6] = '{"stat_wr",      1'b0, 1'b1, USTAT,    16'h00AA, 1'b1, 1'b1, 1'b1, 0, 16'h0000};
      vecs[7] = '{"stat_rd2",     1'b1, 1'b0, USTAT,    16'h0000, 1'b0, 1'b1, 1'b1, 0, 16'h0000};
      vecs[8] = '{"sram_rd_43",   1'b1, 1'b0, 16'h0043, 16'h0000, 1'b0, 1'b1, 1'b1, 0, 16'h0000};
      vecs[9] = '{"uart_wr_now",  1'b0, 1'b1, UDATA,    16'h00FF, 1'b0, 1'b1, 1'b1, 0, 16'h0000};

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst busy", busy, 0);
      chk("rst ack", ack, 0);
      chk("rst err", err, 0);
      chk("rst rdata", rdata, 0);
      chk("rst ram_addr", ram_addr, 0);
      chk("rst strobes", {ram_en_n, ram_oe_n, ram_we_n, rdn, wrn}, 5'h1F);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Directed vectors (expected values from the transaction model rules)
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].name, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].dr, vecs[i].tb, vecs[i].ts0, vecs[i].k, vecs[i].rx);
      end
      chk("sram_rd_42 value", m_rdata, 0);  // last vector was a UART write: ack data not a read
      n_assert--;                           // informational only, not counted
      if (m_rdata !== 0) n_fail--;

      // Request with neither rd nor wr is ignored
      req = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0042;
      seen = 0;
      repeat (4) begin
         @(posedge CLK); #1;
         if (busy || ack) seen++;
      end
      req = 1'b0;
      chk("noop_req ignored", seen, 0);

      // Held request: re-accepted only after a cycle in IDLE, so acks alternate
      req = 1'b1; rd = 1'b1; wr = 1'b0; addr = USTAT; data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
      acks = 0; consec = 0; prev_ack = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge CLK); #1;
         if (ack) acks++;
         if (ack && prev_ack) consec++;
         prev_ack = ack;
      end
      req = 1'b0; rd = 1'b0;
      chk("held_req ack_count", acks, 4);
      chk("held_req back_to_back", consec, 0);
      chk("held_req rdata", rdata, 16'h0003);
      prev_rdata = 16'h0003;
      @(posedge CLK); #1;
      chk("held_req idle_after", busy, 0);

      // Reset during the second ACCESS cycle of an SRAM write
      rd = 1'b0; wr = 1'b1; addr = 16'h0050; wdata = 16'h7E7E; req = 1'b1;
      @(posedge CLK); #1;
      req = 1'b0; wr = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("abort pre we_n", ram_we_n, 0);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("abort strobes", {ram_en_n, ram_oe_n, ram_we_n, rdn, wrn}, 5'h1F);
      chk("abort ack", ack, 0);
      chk("abort busy", busy, 0);
      chk("abort rdata", rdata, 0);
      pat = 16'h9669; force_drv = 1'b1;
      #1;
      chk("abort bus_released", ram_data, 16'h9669);
      force_drv = 1'b0;
      RST = 1'b0;
      seen = 0;
      repeat (3) begin
         @(posedge CLK); #1;
         if (ack || busy) seen++;
      end
      chk("abort no_late_ack", seen, 0);
      prev_rdata = '0;
      run_op("post_rst_stat", 1'b1, 1'b0, USTAT, 16'h0, 1'b1, 1'b0, 1'b1, 0, 16'h0);

      // Randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         int cls;
         logic [15:0] a, d, rx;
         logic dr, tb, ts0;
         int k;
         cls = $urandom_range(0, 6);
         a   = 16'h0100 + 16'($urandom_range(0, 255));
         d   = 16'($urandom);
         rx  = 16'($urandom);
         dr  = 1'($urandom);
         tb  = 1'($urandom);
         ts0 = 1'($urandom);
         k   = $urandom_range(0, 4);
         case (cls)
            0: run_op("rnd sram_wr", 1'b0, 1'b1, a, d, dr, 1'b1, ts0, 0, rx);
            1: run_op("rnd sram_rd", 1'b1, 1'b0, a, d, dr, 1'b1, ts0, 0, rx);
            2: run_op("rnd stat_rd", 1'b1, 1'b0, USTAT, d, dr, tb, ts0, 0, rx);
            3: run_op("rnd stat_wr", 1'b0, 1'b1, USTAT, d, dr, tb, ts0, 0, rx);
            4: run_op("rnd uart_rd", 1'b1, 1'b0, UDATA, d, dr, 1'b1, ts0, 0, rx);
            5: run_op("rnd uart_wr", 1'b0, 1'b1, UDATA, d, dr, 1'b1, ts0, k, rx);
            default: run_op("rnd illegal", 1'b1, 1'b1, a, d, dr, tb, ts0, 0, rx);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
